// File: rtl/spider_supply_ledger.sv
// -----------------------------------------------------------------------------
// spider_supply_ledger
//
// Purpose:
//   Resource ledger for the spider gadget blocks. A request carries web, energy
//   and tracer demands. The ledger checks them against the three on-suit
//   reservoirs. It either grants the request and debits all three reservoirs at
//   once, or denies it and leaves every reservoir untouched. Energy recharges
//   slowly over time. Web and tracers are restocked by refill pulses.
//
// Configuration macro:
//   SPIDER_SUPPLY_RECHARGE_EN
//     Defined   : a free-running counter adds +1 energy every RECHARGE_PERIOD
//                 cycles, saturating at ENERGY_MAX.
//     Undefined : no counter is built. RECHARGE_PERIOD is not declared, and
//                 energy changes only on a debit or a reset.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   req            in   request strobe, sampled only while idle
//   webNeeded      in   [3:0] web demand
//   energyNeeded   in   [7:0] energy demand
//   tracersNeeded  in   [5:0] tracer demand
//   refill_web     in   pulse: web level := WEB_MAX (wins over a debit)
//   refill_tracers in   pulse: tracer level := TRACER_MAX (wins over a debit)
//   busy           out  high while a request is in flight
//   grant          out  one-cycle pulse: request accepted and debited
//   deny           out  one-cycle pulse: request rejected, nothing debited
//   webLevel       out  [3:0] current web reservoir
//   energyLevel    out  [7:0] current energy reservoir
//   tracerLevel    out  [5:0] current tracer reservoir
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spider_supply_ledger #(
    parameter int WEB_MAX    = 15,
    parameter int ENERGY_MAX = 255,
    parameter int TRACER_MAX = 63
`ifdef SPIDER_SUPPLY_RECHARGE_EN
    ,
    parameter int RECHARGE_PERIOD = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [3:0] webNeeded,
    input  logic [7:0] energyNeeded,
    input  logic [5:0] tracersNeeded,
    input  logic       refill_web,
    input  logic       refill_tracers,
    output logic       busy,
    output logic       grant,
    output logic       deny,
    output logic [3:0] webLevel,
    output logic [7:0] energyLevel,
    output logic [5:0] tracerLevel
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RESPOND
    } state_t;

    localparam logic [3:0] WEB_FULL    = 4'(WEB_MAX);
    localparam logic [7:0] ENERGY_FULL = 8'(ENERGY_MAX);
    localparam logic [5:0] TRACER_FULL = 6'(TRACER_MAX);

    state_t     state_q;
    logic       busy_q;
    logic       grant_q;
    logic       deny_q;
    logic [3:0] w_req_q;
    logic [7:0] e_req_q;
    logic [5:0] t_req_q;
    logic [3:0] web_q;
    logic [3:0] web_d;
    logic [7:0] energy_q;
    logic [7:0] energy_d;
    logic [5:0] tracer_q;
    logic [5:0] tracer_d;

    logic       ok;
    logic       debit;
    logic       tick;
    logic [8:0] energy_sum;

    // -------------------------------------------------------------------------
    // Recharge tick: one pulse every RECHARGE_PERIOD cycles.
    // -------------------------------------------------------------------------
`ifdef SPIDER_SUPPLY_RECHARGE_EN
    localparam int RC_W = (RECHARGE_PERIOD > 2) ? $clog2(RECHARGE_PERIOD) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECHARGE_PERIOD - 1);

    logic [RC_W-1:0] rc_q;

    assign tick = (rc_q == RC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc_q <= '0;
        end else begin
            rc_q <= tick ? '0 : rc_q + RC_W'(1);
        end
    end
`else
    assign tick = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next reservoir levels. The ok check uses the levels as they stand now,
    // which are the pre-tick and pre-refill values.
    // -------------------------------------------------------------------------
    always_comb begin
        ok    = (web_q >= w_req_q) && (energy_q >= e_req_q) && (tracer_q >= t_req_q);
        debit = (state_q == CHECK) && ok;

        // A refill overrides a coincident debit. The level lands at MAX.
        web_d    = refill_web     ? WEB_FULL    : (debit ? web_q - w_req_q : web_q);
        tracer_d = refill_tracers ? TRACER_FULL : (debit ? tracer_q - t_req_q : tracer_q);

        // A debit only happens when energy_q >= e_req_q, so the subtraction
        // cannot wrap. The ninth bit catches the +1 tick when energy is full.
        energy_sum = {1'b0, energy_q}
                   - (debit ? {1'b0, e_req_q} : 9'd0)
                   + {8'd0, tick};
        energy_d   = (energy_sum > {1'b0, ENERGY_FULL}) ? ENERGY_FULL : energy_sum[7:0];
    end

    // -------------------------------------------------------------------------
    // Control FSM and all registered state
    // -------------------------------------------------------------------------
    // NOTE: every state register is updated with non-blocking assignments. That
    // way, all reads in this block see the values from before the edge,
    // regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            grant_q  <= 1'b0;
            deny_q   <= 1'b0;
            w_req_q  <= '0;
            e_req_q  <= '0;
            t_req_q  <= '0;
            web_q    <= WEB_FULL;
            energy_q <= ENERGY_FULL;
            tracer_q <= TRACER_FULL;
        end else begin
            web_q    <= web_d;
            energy_q <= energy_d;
            tracer_q <= tracer_d;
            grant_q  <= 1'b0;
            deny_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (req) begin
                        w_req_q <= webNeeded;
                        e_req_q <= energyNeeded;
                        t_req_q <= tracersNeeded;
                        state_q <= CHECK;
                        busy_q  <= 1'b1;
                    end
                end
                CHECK: begin
                    grant_q <= ok;
                    deny_q  <= ~ok;
                    state_q <= RESPOND;
                end
                RESPOND: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign grant       = grant_q;
    assign deny        = deny_q;
    assign webLevel    = web_q;
    assign energyLevel = energy_q;
    assign tracerLevel = tracer_q;

endmodule

// File: tb/tb_spider_supply_ledger.sv
// -----------------------------------------------------------------------------
// tb_spider_supply_ledger
//
// Self-checking bench for spider_supply_ledger.
//
// A reservoir model held as integers predicts every output after every clock
// edge. The model tracks:
//   - the three reservoir levels,
//   - how many busy cycles the current request still has,
//   - the count of edges since reset, which drives the recharge cadence.
//
// Directed scenarios pin the model to hand-computed literals. A long run of
// random traffic then follows.
//
// Build with +define+SPIDER_SUPPLY_RECHARGE_EN to exercise recharge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spider_supply_ledger;

    localparam int W_MAX  = 15;
    localparam int E_MAX  = 255;
    localparam int T_MAX  = 63;
    localparam int PERIOD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [3:0] webNeeded;
    logic [7:0] energyNeeded;
    logic [5:0] tracersNeeded;
    logic       refill_web;
    logic       refill_tracers;
    logic       busy;
    logic       grant;
    logic       deny;
    logic [3:0] webLevel;
    logic [7:0] energyLevel;
    logic [5:0] tracerLevel;

    spider_supply_ledger dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .webNeeded      (webNeeded),
        .energyNeeded   (energyNeeded),
        .tracersNeeded  (tracersNeeded),
        .refill_web     (refill_web),
        .refill_tracers (refill_tracers),
        .busy           (busy),
        .grant          (grant),
        .deny           (deny),
        .webLevel       (webLevel),
        .energyLevel    (energyLevel),
        .tracerLevel    (tracerLevel)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------------------------------------------------------- model
    int m_web;
    int m_energy;
    int m_tracer;
    int m_busy_left;     // busy cycles still ahead for the request in flight
    int m_wr;
    int m_er;
    int m_tr;
    int m_grant;
    int m_deny;
    int m_edges;         // clock edges seen since reset was released

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_web       = W_MAX;
        m_energy    = E_MAX;
        m_tracer    = T_MAX;
        m_busy_left = 0;
        m_wr        = 0;
        m_er        = 0;
        m_tr        = 0;
        m_grant     = 0;
        m_deny      = 0;
        m_edges     = 0;
    endtask

    // Advance the model by one clock edge, using the inputs as currently driven.
    task automatic model_edge();
        int tick;
        int deciding;
        int ok;
        int e;

        tick = 0;
`ifdef SPIDER_SUPPLY_RECHARGE_EN
        if ((m_edges + 1) % PERIOD == 0) tick = 1;
`endif
        deciding = (m_busy_left == 2);
        ok = deciding && (m_web >= m_wr) && (m_energy >= m_er) && (m_tracer >= m_tr);

        m_grant = deciding && ok;
        m_deny  = deciding && !ok;

        e = m_energy - (ok ? m_er : 0) + tick;
        if (e > E_MAX) e = E_MAX;
        m_energy = e;

        m_web    = refill_web     ? W_MAX : m_web    - (ok ? m_wr : 0);
        m_tracer = refill_tracers ? T_MAX : m_tracer - (ok ? m_tr : 0);

        if (m_busy_left == 0) begin
            if (req) begin
                m_wr        = webNeeded;
                m_er        = energyNeeded;
                m_tr        = tracersNeeded;
                m_busy_left = 2;
            end
        end else begin
            m_busy_left--;
        end

        m_edges++;
    endtask

    // One clock cycle: predict, clock, then compare every output 1 ns later.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("busy",   busy,        (m_busy_left != 0) ? 1 : 0);
        check("grant",  grant,       m_grant);
        check("deny",   deny,        m_deny);
        check("web",    webLevel,    m_web);
        check("energy", energyLevel, m_energy);
        check("tracer", tracerLevel, m_tracer);
    endtask

    task automatic idle_inputs();
        req            = 1'b0;
        webNeeded      = '0;
        energyNeeded   = '0;
        tracersNeeded  = '0;
        refill_web     = 1'b0;
        refill_tracers = 1'b0;
    endtask

    task automatic set_req(input int w, input int e, input int t);
        req           = 1'b1;
        webNeeded     = 4'(w);
        energyNeeded  = 8'(e);
        tracersNeeded = 6'(t);
    endtask

    // Asynchronous reset, pulsed away from the active edge. The outputs must
    // respond without waiting for a clock.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check("rst_busy",   busy,        0);
        check("rst_grant",  grant,       0);
        check("rst_deny",   deny,        0);
        check("rst_web",    webLevel,    15);
        check("rst_energy", energyLevel, 255);
        check("rst_tracer", tracerLevel, 63);
        reset = 1'b0;
    endtask

    task automatic run_until(input int edge_target);
        idle_inputs();
        while (m_edges < edge_target) step();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        do_reset();

        // Idle one cycle after reset.
        step();
        check("idle_web",    webLevel,    15);
        check("idle_energy", energyLevel, 255);
        check("idle_tracer", tracerLevel, 63);

        // Taser request (1,16,8): busy for two cycles, grant in the second.
        set_req(1, 16, 8);
        step();
        idle_inputs();
        check("taser_busy1",  busy,  1);
        check("taser_grant1", grant, 0);
        step();
        check("taser_grant2", grant,       1);
        check("taser_web",    webLevel,    14);
        check("taser_energy", energyLevel, 239);
        check("taser_tracer", tracerLevel, 55);
        step();
        check("taser_busy3", busy, 0);

        // Web-shooter request (15,4,0) with web=14 is denied and changes nothing.
        set_req(15, 4, 0);
        step();
        idle_inputs();
        step();
        check("ws_deny",   deny,        1);
        check("ws_web",    webLevel,    14);
        check("ws_energy", energyLevel, 239);
        step();

        // A refill pulse restores web. The same request is then granted.
        refill_web = 1'b1;
        step();
        idle_inputs();
        check("refill_web", webLevel, 15);
        set_req(15, 4, 0);
        step();
        idle_inputs();
        step();
        check("ws2_grant",  grant,       1);
        check("ws2_web",    webLevel,    0);
        check("ws2_energy", energyLevel, 235);
        step();

        // Tracer request (1,1,4) with refill_tracers pulsed on the debit edge.
        refill_web = 1'b1;
        step();
        idle_inputs();
        set_req(1, 1, 4);
        step();
        idle_inputs();
        refill_tracers = 1'b1;
        step();
        refill_tracers = 1'b0;
        check("tr_grant",  grant,       1);
        check("tr_tracer", tracerLevel, 63);
        check("tr_web",    webLevel,    14);
        check("tr_energy", energyLevel, 234);
        step();

`ifdef SPIDER_SUPPLY_RECHARGE_EN
        // Recharge cadence, saturation, and a debit that coincides with a tick.
        do_reset();
        run_until(32);
        check("rc_sat", energyLevel, 255);
        set_req(1, 16, 8);
        step();
        idle_inputs();
        step();
        check("rc_debit", energyLevel, 239);
        run_until(47);
        check("rc_pre_tick", energyLevel, 239);
        run_until(48);
        check("rc_tick", energyLevel, 240);
        run_until(62);
        set_req(0, 1, 0);
        step();
        idle_inputs();
        step();
        check("rc_tick_debit_grant",  grant,       1);
        check("rc_tick_debit_energy", energyLevel, 240);
        step();
`endif

        // A reset during CHECK aborts the request.
        do_reset();
        step();
        set_req(1, 16, 8);
        step();
        idle_inputs();
        check("abort_in_check", busy, 1);
        do_reset();
        step();
        check("abort_no_grant", grant, 0);
        check("abort_no_deny",  deny,  0);
        step();
        check("abort_web", webLevel, 15);

        // req held high while busy is ignored. Demand changes after the latch
        // have no effect.
        set_req(1, 16, 8);
        step();
        set_req(5, 5, 5);
        step();
        check("ign_grant", grant,    1);
        check("ign_web",   webLevel, 14);
        step();
        idle_inputs();
        step();
        check("ign_busy",   busy,        0);
        check("ign_grant2", grant,       0);
        check("ign_energy", energyLevel, m_energy);
        check("ign_web2",   webLevel,    14);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            req           = ($urandom_range(0, 2) == 0);
            webNeeded     = 4'($urandom_range(0, 4));
            energyNeeded  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                        : 8'($urandom_range(0, 12));
            tracersNeeded = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                                        : 6'($urandom_range(0, 10));
            if ($urandom_range(0, 29) == 0) begin
                webNeeded     = '0;
                energyNeeded  = '0;
                tracersNeeded = '0;
            end
            refill_web     = ($urandom_range(0, 19) == 0);
            refill_tracers = ($urandom_range(0, 24) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
